cmos_capture: RTL and testbench

Capture stage directly downstream of the camera source (real sensor or the `generate_cam` pattern model). It samples the 8-bit DVP bus on `cmos_pclk`, discards a configurable number of settling frames after reset, pairs bytes into RGB565 pixels and presents them as a write-enable stream to the frame FIFO in front of the SDRAM writer. It also reports line and frame geometry errors and FIFO overflow.

---
 rtl/cmos_capture_if.sv | 30 +++
 rtl/cmos_capture.sv | 196 +++++++++++++++++++
 tb/tb_cmos_capture.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmos_capture_if.sv
// DVP camera bus, pixel write stream and status flags of the cmos_capture stage.
interface cmos_capture_if;
  logic        cmos_vsyn;
  logic        cmos_href;
  logic [7:0]  cmos_data;
  logic        fifo_full;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        frame_start;
  logic        line_done;
  logic        frame_done;
  logic        line_err;
  logic        frame_err;
  logic        overflow;
  logic [1:0]  dbg_state;

  // pix_valid is a one-cycle write strobe with no backpressure: a pixel formed
  // while fifo_full is high is dropped on the spot and remembered in overflow.
  modport master (
    output cmos_vsyn, cmos_href, cmos_data, fifo_full,
    input  pix_data, pix_valid, frame_start, line_done, frame_done,
    input  line_err, frame_err, overflow, dbg_state
  );

  modport slave (
    input  cmos_vsyn, cmos_href, cmos_data, fifo_full,
    output pix_data, pix_valid, frame_start, line_done, frame_done,
    output line_err, frame_err, overflow, dbg_state
  );
endinterface

// File: rtl/cmos_capture.sv
// Samples the DVP bus, skips settling frames, pairs bytes into RGB565 pixels
// and checks line/frame geometry.
module cmos_capture #(
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 480,
  parameter int SKIP_FRAMES = 2
) (
  input logic           cmos_pclk,
  input logic           rst_n,
  cmos_capture_if.slave cam
);
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SKIP   = 2'd1,
    ST_ARM    = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  localparam logic [10:0] H_LIM   = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM   = 11'(V_ACTIVE);
  localparam logic [3:0]  SKIP_N  = 4'(SKIP_FRAMES);
  localparam logic [10:0] CNT_MAX = 11'd2047;

  // Assertion is immediate, release is retimed to the pixel clock.
  logic [1:0] rst_sync;
  logic       rst_core_n;

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_core_n = rst_sync[1];

  logic       s1_vsyn;
  logic       s1_href;
  logic       s1_vsyn_d;
  logic       s1_href_d;
  logic [7:0] s1_data;
  logic       vs_fall;
  logic       vs_rise;
  logic       hr_fall;

  always_ff @(posedge cmos_pclk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      s1_vsyn   <= 1'b0;
      s1_href   <= 1'b0;
      s1_data   <= 8'h00;
      s1_vsyn_d <= 1'b0;
      s1_href_d <= 1'b0;
    end else begin
      s1_vsyn   <= cam.cmos_vsyn;
      s1_href   <= cam.cmos_href;
      s1_data   <= cam.cmos_data;
      s1_vsyn_d <= s1_vsyn;
      s1_href_d <= s1_href;
    end
  end

  assign vs_fall = s1_vsyn_d & ~s1_vsyn;
  assign vs_rise = ~s1_vsyn_d & s1_vsyn;
  assign hr_fall = s1_href_d & ~s1_href;

  state_t      state;
  state_t      state_next;
  logic        frame_begin;
  logic        frame_end;
  logic [3:0]  skip_cnt;

  always_ff @(posedge cmos_pclk or negedge rst_core_n) begin
    if (!rst_core_n) state <= ST_IDLE;
    else             state <= state_next;
  end

  // IDLE waits for blanking so capture can never begin in the middle of a frame.
  always_comb begin
    state_next  = state;
    frame_begin = 1'b0;
    frame_end   = 1'b0;
    case (state)
      ST_IDLE:   if (s1_vsyn) state_next = ST_SKIP;
      ST_SKIP:   if (skip_cnt == SKIP_N) state_next = ST_ARM;
      ST_ARM: begin
        if (vs_fall) begin
          state_next  = ST_ACTIVE;
          frame_begin = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (vs_rise) begin
          state_next = ST_ARM;
          frame_end  = 1'b1;
        end
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  logic        byte_sel;
  logic [7:0]  hi_byte;
  logic [10:0] pix_cnt;
  logic [10:0] line_cnt;
  logic [10:0] line_cnt_inc;
  logic [10:0] pix_cnt_inc;
  logic        in_line;
  logic        pix_form;
  logic        pix_ok;
  logic        line_end;

  assign in_line      = (state == ST_ACTIVE) & s1_href;
  assign pix_form     = in_line & byte_sel;
  assign line_end     = (state == ST_ACTIVE) & hr_fall;
  assign pix_ok       = (pix_cnt < H_LIM) & (line_cnt < V_LIM);
  assign line_cnt_inc = (line_cnt == CNT_MAX) ? line_cnt : line_cnt + 11'd1;
  assign pix_cnt_inc  = (pix_cnt == CNT_MAX) ? pix_cnt : pix_cnt + 11'd1;

  logic [15:0] pix_data_q;
  logic        pix_valid_q;
  logic        frame_start_q;
  logic        line_done_q;
  logic        frame_done_q;
  logic        line_err_q;
  logic        frame_err_q;
  logic        overflow_q;

  always_ff @(posedge cmos_pclk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      skip_cnt      <= 4'd0;
      byte_sel      <= 1'b0;
      hi_byte       <= 8'h00;
      pix_cnt       <= 11'd0;
      line_cnt      <= 11'd0;
      pix_data_q    <= 16'h0000;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      line_done_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      frame_start_q <= frame_begin;
      frame_done_q  <= frame_end;
      line_done_q   <= line_end;
      pix_valid_q   <= 1'b0;

      if (state == ST_IDLE) begin
        skip_cnt <= 4'd0;
      end else if (state == ST_SKIP && vs_fall && skip_cnt != SKIP_N) begin
        skip_cnt <= skip_cnt + 4'd1;
      end

      byte_sel <= in_line ? ~byte_sel : 1'b0;
      if (in_line && !byte_sel) hi_byte <= s1_data;

      // Overflow only counts pixels that would otherwise have been written.
      if (pix_form) begin
        pix_cnt <= pix_cnt_inc;
        if (pix_ok && !cam.fifo_full) begin
          pix_data_q  <= {hi_byte, s1_data};
          pix_valid_q <= 1'b1;
        end else if (pix_ok) begin
          overflow_q <= 1'b1;
        end
      end

      if (line_end) begin
        line_cnt <= line_cnt_inc;
        pix_cnt  <= 11'd0;
        if (pix_cnt != H_LIM || byte_sel) line_err_q <= 1'b1;
      end

      // A line ending on the same edge as the frame still counts toward it.
      if (frame_end) begin
        frame_err_q <= ((line_end ? line_cnt_inc : line_cnt) != V_LIM);
        if (s1_href) line_err_q <= 1'b1;
      end

      if (frame_begin) begin
        line_err_q <= 1'b0;
        line_cnt   <= 11'd0;
        pix_cnt    <= 11'd0;
      end
    end
  end

  assign cam.pix_data    = pix_data_q;
  assign cam.pix_valid   = pix_valid_q;
  assign cam.frame_start = frame_start_q;
  assign cam.line_done   = line_done_q;
  assign cam.frame_done  = frame_done_q;
  assign cam.line_err    = line_err_q;
  assign cam.frame_err   = frame_err_q;
  assign cam.overflow    = overflow_q;
  assign cam.dbg_state   = state;
endmodule

// File: tb/tb_cmos_capture.sv
// Testbench for cmos_capture on a reduced frame geometry.
module tb_cmos_capture;
  localparam int H    = 8;
  localparam int V    = 4;
  localparam int SKIP = 2;
  localparam int VB   = 6;
  localparam int FP   = 3;
  localparam int BP   = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  cmos_capture_if cam ();

  cmos_capture #(
    .H_ACTIVE    (H),
    .V_ACTIVE    (V),
    .SKIP_FRAMES (SKIP)
  ) dut (
    .cmos_pclk (clk),
    .rst_n     (rst_n),
    .cam       (cam)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int tests  = 0;
  int failed = 0;

  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];
  int          fs_q[$];
  int          ld_q[$];
  int          fd_q[$];

  int pv_cnt = 0;
  int ld_cnt = 0;
  int fs_cnt = 0;
  int fd_cnt = 0;

  int   frame_no;
  logic capt;
  logic line_err_m;
  logic frame_err_m;
  logic ov_m;
  int   exp_pix_frame;
  int   exp_ld_n;
  int   exp_fs_n;
  int   exp_fd_n;
  int   frame_pv;

  int   line_len [0:7];
  int   rst_line = -1;
  int   ff_line  = -1;
  int   ff_start = 0;
  int   ff_len   = 0;
  logic ff_rand  = 1'b0;
  logic dir_first = 1'b0;

  logic [7:0] lb [0:39];
  logic       ff_arr [0:39];

  logic [15:0] mon_d;
  int          mon_c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  always @(negedge clk) begin
    if (cam.pix_valid === 1'b1) begin
      pv_cnt++;
      check("pix_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_d = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("pix_data", 32'(cam.pix_data), 32'(mon_d));
        check("pix_cycle", 32'(cyc), 32'(mon_c));
      end
    end
    if (cam.line_done === 1'b1) begin
      ld_cnt++;
      check("ld_expected", 32'(ld_q.size() != 0), 32'd1);
      if (ld_q.size() != 0) begin
        mon_c = ld_q.pop_front();
        check("ld_cycle", 32'(cyc), 32'(mon_c));
      end
    end
    if (cam.frame_start === 1'b1) begin
      fs_cnt++;
      check("fs_expected", 32'(fs_q.size() != 0), 32'd1);
      if (fs_q.size() != 0) begin
        mon_c = fs_q.pop_front();
        check("fs_cycle", 32'(cyc), 32'(mon_c));
      end
    end
    if (cam.frame_done === 1'b1) begin
      fd_cnt++;
      check("fd_expected", 32'(fd_q.size() != 0), 32'd1);
      if (fd_q.size() != 0) begin
        mon_c = fd_q.pop_front();
        check("fd_cycle", 32'(cyc), 32'(mon_c));
      end
    end
  end

  task automatic drive(input logic vs, input logic hr, input logic [7:0] d, input logic ff);
    cam.cmos_vsyn = vs;
    cam.cmos_href = hr;
    cam.cmos_data = d;
    cam.fifo_full = ff;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pix_data"},    32'(cam.pix_data),    32'd0);
    check({tag, "_pix_valid"},   32'(cam.pix_valid),   32'd0);
    check({tag, "_frame_start"}, 32'(cam.frame_start), 32'd0);
    check({tag, "_line_done"},   32'(cam.line_done),   32'd0);
    check({tag, "_frame_done"},  32'(cam.frame_done),  32'd0);
    check({tag, "_line_err"},    32'(cam.line_err),    32'd0);
    check({tag, "_frame_err"},   32'(cam.frame_err),   32'd0);
    check({tag, "_overflow"},    32'(cam.overflow),    32'd0);
  endtask

  task automatic set_nominal();
    for (int i = 0; i < 8; i++) line_len[i] = 2 * H;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    check("midrst_q_empty", 32'(exp_q.size()), 32'd0);
    frame_no    = 0;
    capt        = 1'b0;
    line_err_m  = 1'b0;
    frame_err_m = 1'b0;
    ov_m        = 1'b0;
    @(posedge clk);
    #1;
    for (int j = 0; j < 3; j++) drive(1'b0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
  endtask

  // Pixel p is decided by its two bytes and by fifo_full one cycle after its second byte.
  task automatic drive_line(input int li, input int nb);
    int p;
    for (int i = 0; i < 40; i++) begin
      lb[i]     = 8'($urandom);
      ff_arr[i] = 1'b0;
    end
    if (dir_first && li == 0) begin
      lb[0] = 8'h80; lb[1] = 8'h00; lb[2] = 8'h04; lb[3] = 8'h00;
    end
    if (ff_rand) for (int i = 0; i < 40; i++) ff_arr[i] = ($urandom_range(0, 3) == 0);
    if (li == ff_line) for (int i = ff_start; i < ff_start + ff_len; i++) ff_arr[i] = 1'b1;
    for (int j = 0; j < FP; j++) drive(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < nb; i++) begin
      if (capt && (i % 2 == 1)) begin
        p = i / 2;
        if (li < V && p < H) begin
          if (ff_arr[i + 1]) ov_m = 1'b1;
          else begin
            exp_q.push_back({lb[i - 1], lb[i]});
            exp_cyc_q.push_back(cyc + 2);
            exp_pix_frame++;
          end
        end
      end
      drive(1'b0, 1'b1, lb[i], ff_arr[i]);
    end
    if (capt) begin
      ld_q.push_back(cyc + 2);
      exp_ld_n++;
    end
    for (int j = 0; j < BP; j++) drive(1'b0, 1'b0, 8'h00, ff_arr[nb + j]);
    if (capt) begin
      if (nb != 2 * H) line_err_m = 1'b1;
      check("line_err_after_line", 32'(cam.line_err), 32'(line_err_m));
    end
  endtask

  task automatic drive_frame(input int nlines);
    int pv0, ld0, fs0, fd0;
    pv0 = pv_cnt; ld0 = ld_cnt; fs0 = fs_cnt; fd0 = fd_cnt;
    exp_pix_frame = 0; exp_ld_n = 0; exp_fs_n = 0; exp_fd_n = 0;
    for (int j = 0; j < VB; j++) drive(1'b1, 1'b0, 8'h00, 1'b0);
    frame_no++;
    capt = (frame_no > SKIP);
    if (capt) begin
      fs_q.push_back(cyc + 2);
      exp_fs_n++;
      line_err_m = 1'b0;
    end
    for (int li = 0; li < nlines; li++) begin
      if (li == rst_line) do_reset();
      drive_line(li, line_len[li]);
    end
    for (int j = 0; j < 2; j++) drive(1'b0, 1'b0, 8'h00, 1'b0);
    if (capt) begin
      fd_q.push_back(cyc + 2);
      exp_fd_n++;
      frame_err_m = (nlines != V);
    end
    for (int j = 0; j < 3; j++) drive(1'b1, 1'b0, 8'h00, 1'b0);
    frame_pv = pv_cnt - pv0;
    check("frame_pix_count", 32'(frame_pv), 32'(exp_pix_frame));
    check("frame_pix_q_empty", 32'(exp_q.size()), 32'd0);
    check("frame_ld_count", 32'(ld_cnt - ld0), 32'(exp_ld_n));
    check("frame_fs_count", 32'(fs_cnt - fs0), 32'(exp_fs_n));
    check("frame_fd_count", 32'(fd_cnt - fd0), 32'(exp_fd_n));
    check("frame_line_err", 32'(cam.line_err), 32'(line_err_m));
    check("frame_frame_err", 32'(cam.frame_err), 32'(frame_err_m));
    check("frame_overflow", 32'(cam.overflow), 32'(ov_m));
  endtask

  initial begin
    rst_n         = 1'b0;
    cam.cmos_vsyn = 1'b0;
    cam.cmos_href = 1'b0;
    cam.cmos_data = 8'h00;
    cam.fifo_full = 1'b0;
    frame_no      = 0;
    capt          = 1'b0;
    line_err_m    = 1'b0;
    frame_err_m   = 1'b0;
    ov_m          = 1'b0;
    set_nominal();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    check("reset_state", 32'(cam.dbg_state), 32'd0);
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) drive(1'b0, 1'b0, 8'h00, 1'b0);

    // Settling frames produce nothing.
    drive_frame(V);
    check("skip1_no_pix", 32'(frame_pv), 32'd0);
    drive_frame(V);
    check("skip2_no_pix", 32'(frame_pv), 32'd0);

    // First captured frame, starting with the byte-order pattern.
    dir_first = 1'b1;
    drive_frame(V);
    dir_first = 1'b0;
    check("frame3_pix", 32'(frame_pv), 32'(V * H));

    // Short line.
    line_len[1] = 2 * H - 2;
    drive_frame(V);
    set_nominal();

    // Odd byte count, then a missing line.
    line_len[2] = 2 * H + 1;
    drive_frame(V);
    set_nominal();
    drive_frame(V - 1);

    // Over-long line plus one extra line beyond V.
    line_len[0] = 2 * H + 4;
    drive_frame(V + 1);
    set_nominal();

    // fifo_full held 10 cycles in mid-line.
    ff_line = 1; ff_start = 4; ff_len = 10;
    drive_frame(V);
    ff_line = -1;
    check("ovf_pix", 32'(frame_pv), 32'(V * H - 5));
    check("ovf_flag", 32'(cam.overflow), 32'd1);

    // Random backpressure.
    ff_rand = 1'b1;
    drive_frame(V);
    ff_rand = 1'b0;

    // Reset in mid-frame, then settling frames again before capture resumes.
    rst_line = 2;
    drive_frame(V);
    rst_line = -1;
    drive_frame(V);
    check("post_rst_skip1", 32'(frame_pv), 32'd0);
    drive_frame(V);
    check("post_rst_skip2", 32'(frame_pv), 32'd0);
    drive_frame(V);
    check("post_rst_capture", 32'(frame_pv), 32'(V * H));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
